// File: rtl/calc_sequencer.sv
// Keypad-to-arithmetic sequencer: builds signed operands from key tokens, fires the
// arithmetic unit with a one-cycle calc_en pulse and captures its answer for display.
module calc_sequencer #(
  parameter int WAIT_CYC = 2,
  parameter int MAX_MAG  = 999999,
  parameter int NEG_MAG  = 99999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [4:0]         key_code,
  input  logic signed [31:0] ans,
  output logic signed [31:0] operand1,
  output logic signed [31:0] operand2,
  output logic [2:0]         operator,
  output logic               calc_en,
  output logic signed [31:0] display,
  output logic               err,
  output logic               busy
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [2:0] {
    S_OPND1,
    S_OP,
    S_OPND2,
    S_FIRE,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        mag_q, mag_d;
  logic               neg_q, neg_d;
  logic signed [31:0] op1_q, op1_d;
  logic signed [31:0] op2_q, op2_d;
  logic [2:0]         opr_q, opr_d;
  logic [2:0]         pend_q, pend_d;
  logic signed [31:0] disp_q, disp_d;
  logic               err_q, err_d;
  logic               en_q, en_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               isDigit, isEq, isOp, isClr, isSign;
  logic [3:0]         digit;
  logic [2:0]         opCode;
  logic [27:0]        digMag;
  logic               digOk, signOk, togNeg;
  logic signed [31:0] digVal, togVal, oneDigVal;
  logic [31:0]        ansAbs;
  logic               showSignOk, ansIsErr;

  // The entry register keeps magnitude and sign apart; a zero entry is never negative.
  function automatic logic signed [31:0] toVal(input logic [23:0] m, input logic n);
    logic signed [31:0] v;
    v = $signed({8'd0, m});
    return n ? -v : v;
  endfunction

  always_comb begin
    isDigit    = key_valid && (key_code <= 5'd9);
    isEq       = key_valid && (key_code == 5'd10);
    isOp       = key_valid && (key_code >= 5'd11) && (key_code <= 5'd15);
    isClr      = key_valid && (key_code == 5'd16);
    isSign     = key_valid && (key_code == 5'd17);
    digit      = key_code[3:0];
    opCode     = 3'(key_code - 5'd10);
    digMag     = 28'(mag_q) * 28'd10 + 28'(digit);
    digOk      = digMag <= 28'(MAX_MAG);
    digVal     = toVal(digMag[23:0], neg_q);
    oneDigVal  = $signed({28'd0, digit});
    signOk     = mag_q <= 24'(NEG_MAG);
    togNeg     = ~neg_q && (mag_q != 24'd0);
    togVal     = toVal(mag_q, togNeg);
    ansAbs     = op1_q[31] ? 32'(-op1_q) : 32'(op1_q);
    showSignOk = ansAbs <= 32'(NEG_MAG);
    ansIsErr   = (ans == 32'sh00EE0000) || (ans == 32'sh00CC0000);
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opr_d   = opr_q;
    pend_d  = pend_q;
    disp_d  = disp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;

    case (state_q)
      S_OPND1: begin
        if (isDigit && digOk) begin
          mag_d  = digMag[23:0];
          op1_d  = digVal;
          disp_d = digVal;
        end else if (isSign && signOk) begin
          neg_d  = togNeg;
          op1_d  = togVal;
          disp_d = togVal;
        end else if (isOp) begin
          opr_d   = opCode;
          mag_d   = '0;
          neg_d   = 1'b0;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (isDigit) begin
          mag_d   = {20'd0, digit};
          neg_d   = 1'b0;
          op2_d   = oneDigVal;
          disp_d  = oneDigVal;
          state_d = S_OPND2;
        end else if (isOp) begin
          opr_d = opCode;
        end
      end
      S_OPND2: begin
        if (isDigit && digOk) begin
          mag_d  = digMag[23:0];
          op2_d  = digVal;
          disp_d = digVal;
        end else if (isSign && signOk) begin
          neg_d  = togNeg;
          op2_d  = togVal;
          disp_d = togVal;
        end else if (isEq) begin
          pend_d  = 3'd0;
          state_d = S_FIRE;
        end else if (isOp) begin
          pend_d  = opCode;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CW'(WAIT_CYC - 1)) begin
          disp_d = ans;
          if (ansIsErr) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            op1_d = ans;
            if (pend_q != 3'd0) begin
              opr_d   = pend_q;
              pend_d  = 3'd0;
              mag_d   = '0;
              neg_d   = 1'b0;
              state_d = S_OP;
            end else begin
              state_d = S_SHOW;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW: begin
        if (isDigit) begin
          mag_d   = {20'd0, digit};
          neg_d   = 1'b0;
          op1_d   = oneDigVal;
          disp_d  = oneDigVal;
          state_d = S_OPND1;
        end else if (isOp) begin
          opr_d   = opCode;
          mag_d   = '0;
          neg_d   = 1'b0;
          state_d = S_OP;
        end else if (isEq) begin
          pend_d  = 3'd0;
          state_d = S_FIRE;
        end else if (isSign && showSignOk) begin
          mag_d   = ansAbs[23:0];
          neg_d   = ~op1_q[31] && (ansAbs != 32'd0);
          op1_d   = -op1_q;
          disp_d  = -op1_q;
          state_d = S_OPND1;
        end
      end
      S_ERR: ;
      default: state_d = S_OPND1;
    endcase

    // Clear is honoured everywhere except while a calculation is in flight.
    if (isClr && (state_q != S_FIRE) && (state_q != S_WAIT)) begin
      state_d = S_OPND1;
      mag_d   = '0;
      neg_d   = 1'b0;
      op1_d   = '0;
      op2_d   = '0;
      opr_d   = '0;
      pend_d  = '0;
      disp_d  = '0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end

    en_d = (state_d == S_FIRE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OPND1;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      opr_q   <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opr_q   <= opr_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

  assign operand1 = op1_q;
  assign operand2 = op2_q;
  assign operator = opr_q;
  assign calc_en  = en_q;
  assign display  = disp_q;
  assign err      = err_q;
  assign busy     = (state_q == S_FIRE) || (state_q == S_WAIT);

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected calc_en launches are queued by the
// stimulus and checked by an independent monitor; a simple arithmetic model drives ans.
module tb_calc_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               key_valid = 1'b0;
  logic [4:0]         key_code = 5'd0;
  logic signed [31:0] ans = 32'sd0;
  logic signed [31:0] operand1, operand2, display;
  logic [2:0]         operator;
  logic               calc_en, err, busy;

  typedef struct packed {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [2:0]  op;
  } fire_t;

  fire_t expQ[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    pulses     = 0;
  int    p0;

  calc_sequencer #(.WAIT_CYC(2), .MAX_MAG(999999), .NEG_MAG(99999)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .ans(ans),
    .operand1(operand1), .operand2(operand2), .operator(operator), .calc_en(calc_en),
    .display(display), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Arithmetic unit stand-in: latches its result on the calc_en rising edge.
  function automatic logic signed [31:0] arith(input logic signed [31:0] a,
                                               input logic signed [31:0] b,
                                               input logic [2:0] op);
    case (op)
      3'd1: return a * b;
      3'd2: return (b == 0) ? 32'sh00EE0000 : a / b;
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: return (b == 0) ? 32'sh00CC0000 : a % b;
      default: return 32'sd0;
    endcase
  endfunction

  always @(posedge calc_en) ans = arith(operand1, operand2, operator);

  always @(negedge clk) begin : monitor
    fire_t e;
    if (calc_en) begin
      pulses++;
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_pulse: got op1=%0d op2=%0d opr=%0d, required no pulse",
                 operand1, operand2, operator);
      end else begin
        e = expQ.pop_front();
        if ({operand1, operand2, operator} !== e) begin
          mismatched++;
          $display("[TB] FAIL fire: got op1=%0d op2=%0d opr=%0d, required op1=%0d op2=%0d opr=%0d",
                   operand1, operand2, operator, $signed(e.o1), $signed(e.o2), e.op);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic applyStimulus(input logic [4:0] code);
    @(posedge clk);
    #1 key_valid = 1'b1;
    key_code = code;
    @(posedge clk);
    #1 key_valid = 1'b0;
    key_code = 5'd0;
  endtask

  task automatic expectFire(input int o1, input int o2, input int op);
    expQ.push_back({32'(o1), 32'(o2), 3'(op)});
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic waitPulse();
    int n = 0;
    @(negedge clk);
    while (!calc_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pulse_timeout", {31'd0, calc_en}, 32'd1);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_operand1", operand1, 0);
    checkOutput("rst_operand2", operand2, 0);
    checkOutput("rst_operator", {29'd0, operator}, 0);
    checkOutput("rst_calc_en", {31'd0, calc_en}, 0);
    checkOutput("rst_display", display, 0);
    checkOutput("rst_err_busy", {30'd0, err, busy}, 0);
    rst = 1'b1;

    // 12 + 3 =
    applyStimulus(1); applyStimulus(2);
    @(negedge clk);
    checkOutput("t1_entry_display", display, 12);
    checkOutput("t1_entry_operand1", operand1, 12);
    applyStimulus(13); applyStimulus(3);
    expectFire(12, 3, 3);
    applyStimulus(10);
    waitIdle();
    checkOutput("t1_display", display, 15);
    checkOutput("t1_err", {31'd0, err}, 0);

    // 7 * 6 + 2 = with chaining
    applyStimulus(16);
    p0 = pulses;
    applyStimulus(7); applyStimulus(11); applyStimulus(6);
    expectFire(7, 6, 1);
    applyStimulus(13);
    waitIdle();
    checkOutput("t2_chain_display", display, 42);
    checkOutput("t2_chain_operator", {29'd0, operator}, 3);
    applyStimulus(2);
    expectFire(42, 2, 3);
    applyStimulus(10);
    waitIdle();
    checkOutput("t2_display", display, 44);
    checkOutput("t2_pulses", pulses - p0, 2);

    // 5 / 0 = -> error lock-out
    applyStimulus(16);
    applyStimulus(5); applyStimulus(12); applyStimulus(0);
    expectFire(5, 0, 2);
    applyStimulus(10);
    waitIdle();
    checkOutput("t3_err", {31'd0, err}, 1);
    checkOutput("t3_display", display, 32'h00EE0000);
    applyStimulus(3); applyStimulus(13); applyStimulus(10);
    repeat (6) @(negedge clk);
    checkOutput("t3_locked_err", {31'd0, err}, 1);
    checkOutput("t3_locked_display", display, 32'h00EE0000);
    applyStimulus(16);
    @(negedge clk);
    checkOutput("t3_clr_err", {31'd0, err}, 0);
    checkOutput("t3_clr_display", display, 0);
    checkOutput("t3_clr_operands", operand1 | operand2, 0);
    checkOutput("t3_clr_operator", {29'd0, operator}, 0);

    // magnitude and sign-toggle limits
    for (int i = 0; i < 7; i++) applyStimulus(9);
    @(negedge clk);
    checkOutput("t4_max_mag", display, 999999);
    applyStimulus(17);
    @(negedge clk);
    checkOutput("t4_toggle_dropped", display, 999999);
    applyStimulus(16);
    for (int i = 1; i <= 5; i++) applyStimulus(5'(i));
    applyStimulus(17);
    @(negedge clk);
    checkOutput("t4_negated", display, -12345);
    checkOutput("t4_negated_op1", operand1, -12345);
    applyStimulus(6);
    @(negedge clk);
    checkOutput("t4_neg_digit", display, -123456);
    applyStimulus(17);
    @(negedge clk);
    checkOutput("t4_neg_toggle_dropped", display, -123456);

    // 8 - 3 = then repeated '=', with keys strobed while busy
    applyStimulus(16);
    applyStimulus(8); applyStimulus(14); applyStimulus(3);
    expectFire(8, 3, 4);
    applyStimulus(10);
    waitIdle();
    checkOutput("t5_first", display, 5);
    expectFire(5, 3, 4);
    applyStimulus(10);
    applyStimulus(7);
    waitIdle();
    checkOutput("t5_repeat", display, 2);
    checkOutput("t5_busy_digit_dropped", operand2, 3);
    expectFire(2, 3, 4);
    applyStimulus(10);
    applyStimulus(16);
    waitIdle();
    checkOutput("t5_busy_clear_dropped", display, -1);

    // reset in the middle of a calculation
    applyStimulus(16);
    applyStimulus(4); applyStimulus(13); applyStimulus(1);
    expectFire(4, 1, 3);
    key_valid = 1'b1; key_code = 5'd10;
    waitPulse();
    key_valid = 1'b0; key_code = 5'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("t6_rst_operand1", operand1, 0);
    checkOutput("t6_rst_display", display, 0);
    checkOutput("t6_rst_busy_en", {30'd0, busy, calc_en}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t6_after_display", display, 0);
    checkOutput("t6_after_busy", {31'd0, busy}, 0);

    checkOutput("pending_fires", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Keypad-to-arithmetic controller for the FPGA calculator. Converts a stream of decoded key tokens into signed operands and a 3-bit operator code, then drives the arithmetic unit's enable edge and captures its answer.
- Supports operation chaining, sign toggle, clear and error lock-out.
- Sits between the keypad decoder and the arithmetic unit; feeds the 7-segment display driver.

Parameters:
- WAIT_CYC, 2, clocks from the calc_en rising edge to sampling ans (must be ≥1).
- MAX_MAG, 999999, largest operand magnitude accepted during digit entry.
- NEG_MAG, 99999, largest magnitude that may be negated.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe; key_code is valid in that cycle
- key_code  in  5  0-9 digit, 10 '=', 11 '*', 12 '/', 13 '+', 14 '-', 15 '%', 16 clear, 17 sign toggle; 18-31 ignored
- ans  in  32 signed  answer returned by the arithmetic unit
- operand1  out  32 signed  first operand to the arithmetic unit
- operand2  out  32 signed  second operand to the arithmetic unit
- operator  out  3  1 '*', 2 '/', 3 '+', 4 '-', 5 '%', 0 none
- calc_en  out  1  registered one-cycle high pulse; its rising edge launches the arithmetic unit
- display  out  32 signed  value to show
- err  out  1  error lock-out flag
- busy  out  1  high in S_FIRE and S_WAIT

Behaviour:
- Reset (asynchronous, rst=0): every output is 0, entry register = 0, state = S_OPND1. Reset asserted mid-calculation aborts it immediately; no further calc_en pulse is issued.
- Operator key mapping: key 11→1, 12→2, 13→3, 14→4, 15→5.
- Digit entry into entry register e:
  - New value = |e|*10 + d, carrying e's sign.
  - Accepted only if the new magnitude ≤ MAX_MAG; otherwise the key is dropped.
  - While e = 0, digit 0 leaves e = 0.
- Sign toggle: e = -e, only if |e| ≤ NEG_MAG; otherwise dropped.
- display = e in entry states; display = last captured ans in S_SHOW and S_ERR.
- States and transitions:
  - S_OPND1
    - digit → enter into e, operand1 = e.
    - op → latch operator, e = 0, go S_OP.
    - '=' → ignored.
  - S_OP
    - digit → e = d, go S_OPND2.
    - op → replace operator.
    - '=' → ignored.
    - sign toggle → ignored.
  - S_OPND2
    - digit → enter into e, operand2 = e.
    - '=' → go S_FIRE, pend = none.
    - op → go S_FIRE, pend = new op.
  - S_FIRE: calc_en = 1 for exactly 1 cycle; operand1, operand2 and operator are held stable (they were stable ≥1 cycle before the edge). Next state S_WAIT, counter = 0.
  - S_WAIT: count WAIT_CYC cycles, then sample ans.
    - ans = 0x00EE0000 or 0x00CC0000 → err = 1, go S_ERR.
    - Otherwise operand1 = ans, display = ans.
    - If pend ≠ none: operator = pend, e = 0, go S_OP. Else go S_SHOW.
  - S_SHOW
    - digit → operand1 = e = d, go S_OPND1.
    - op → operand1 = ans (already), latch op, go S_OP.
    - '=' → repeat the last operation: go S_FIRE with operand2 unchanged.
    - sign toggle → treated like entry on e = ans, go S_OPND1.
  - S_ERR: every key except clear is ignored; err stays 1.
- Clear (16), in any state except S_FIRE/S_WAIT: all registers to reset values, err = 0, state S_OPND1.
- Busy: key_valid during S_FIRE/S_WAIT is dropped, including clear.
- Arithmetic: no arithmetic on results. Operand widths are 32-bit signed; digit entry uses a 24-bit magnitude internally, sign-extended to 32 bits.
- Latency: '=' strobe at cycle t → calc_en high at t+1 → ans sampled and display updated at t+2+WAIT_CYC.

Test Plan:
- Reset, keys 1,2,+,3,= → calc_en single pulse with operand1=12, operand2=3, operator=3; display=15, state S_SHOW, err=0.
- Keys 7,*,6,+,2,= → first pulse 7*6, display 42 during S_OP, second pulse operand1=42, operand2=2 → display 44; exactly 2 calc_en pulses.
- Keys 5,/,0,= with ans returning 0x00EE0000 → err=1; digits/ops ignored; clear → err=0, display=0, operands 0.
- Keys 9 ×7 → e stops at 999999 (7th digit dropped); sign toggle dropped; clear then 1,2,3,4,5, sign toggle → display -12345.
- Keys 8,-,3,= then '=' again → display 5, then 2 (repeat with operand2=3); a key strobed during busy is dropped.
- Assert rst=0 one cycle after calc_en → all outputs 0 immediately, no further calc_en pulse after release.
